gates_sweep_ctrl: RTL and testbench

//  Self-test sequencer for the 2-input gates block (a,b -> c1..c7).
//  On start it drives a,b through 00,01,10,11, waits a settle window per vector,

---
 rtl/gates_sweep_ctrl.sv | 140 ++++++++++++++
 tb/tb_gates_sweep_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gates_sweep_ctrl.sv
// Self-test sequencer for a 2-input gates block: sweeps {a,b} through 00..11,
// checks all seven outputs against the truth table and reports the result.
module gates_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          STOP_ON_FAIL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       gate_a,
    output logic       gate_b,
    input  logic [6:0] gate_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_mask,
    output logic [2:0] fail_count,
    output logic [1:0] first_fail
);

    typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pass_q, pass_d;
    logic [6:0] mask_q, mask_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic [1:0] first_q, first_d;

    logic       exp_a, exp_b;
    logic [6:0] expected;
    logic [6:0] diff;
    logic       mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
            fcnt_q  <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            fcnt_q  <= fcnt_d;
            first_q <= first_d;
        end
    end

    // Expected {c7..c1} for the vector currently driven.
    assign exp_a    = vec_q[1];
    assign exp_b    = vec_q[0];
    assign expected = {~exp_a, ~(exp_a ^ exp_b), exp_a ^ exp_b, ~(exp_a | exp_b),
                       ~(exp_a & exp_b), exp_a | exp_b, exp_a & exp_b};
    assign diff     = gate_c ^ expected;
    assign mismatch = |diff;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        mask_d  = mask_q;
        fcnt_d  = fcnt_q;
        first_d = first_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDrive;
                    vec_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    mask_d  = '0;
                    fcnt_d  = '0;
                    first_d = '0;
                end
            end
            StDrive: begin
                if (cnt_q == SettleLast) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    mask_d = mask_q | diff;
                    fcnt_d = fcnt_q + 3'd1;
                    if (fcnt_q == 3'd0) begin
                        first_d = vec_q;
                    end
                end
                if (vec_q == 2'd3 || (STOP_ON_FAIL && mismatch)) begin
                    state_d = StDone;
                    pass_d  = ((mask_q | diff) == 7'd0);
                end else begin
                    state_d = StDrive;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        gate_a = 1'b0;
        gate_b = 1'b0;
        unique case (state_q)
            StDrive, StCheck: begin
                busy   = 1'b1;
                gate_a = vec_q[1];
                gate_b = vec_q[0];
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign pass       = pass_q;
    assign fail_mask  = mask_q;
    assign fail_count = fcnt_q;
    assign first_fail = first_q;

endmodule

// File: tb/tb_gates_sweep_ctrl.sv
// Directed bench for gates_sweep_ctrl: three instances (default, stop-on-fail,
// one-cycle settle), each beside a gates model with injectable stuck bits.
module tb_gates_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start;
    logic       glitch;
    logic [6:0] s0 [3];
    logic [6:0] s1 [3];

    wire  [2:0] busy, done, pass, ga, gb;
    wire  [6:0] fmask [3];
    wire  [6:0] gc [3];
    wire  [2:0] fcnt [3];
    wire  [1:0] ffirst [3];

    int tests = 0;
    int fails = 0;

    logic       obs_busy [64];
    logic       obs_done [64];
    logic [1:0] obs_ab [64];
    logic       obs_pass [64];
    logic [6:0] obs_mask [64];
    logic [2:0] obs_cnt [64];
    logic [1:0] obs_ff [64];

    // Hand-written truth table, {c7..c1}.
    function automatic logic [6:0] truth(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 7'b1101100;
            2'b01:   return 7'b1010110;
            2'b10:   return 7'b0010110;
            default: return 7'b0100011;
        endcase
    endfunction

    assign gc[0] = (truth(ga[0], gb[0]) & ~s0[0]) | s1[0];
    assign gc[1] = (truth(ga[1], gb[1]) & ~s0[1]) | s1[1];
    assign gc[2] = ((truth(ga[2], gb[2]) & ~s0[2]) | s1[2]) ^ {5'b0, glitch, 1'b0};

    gates_sweep_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .gate_a(ga[0]), .gate_b(gb[0]),
        .gate_c(gc[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .fail_mask(fmask[0]), .fail_count(fcnt[0]), .first_fail(ffirst[0])
    );

    gates_sweep_ctrl #(.STOP_ON_FAIL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .gate_a(ga[1]), .gate_b(gb[1]),
        .gate_c(gc[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .fail_mask(fmask[1]), .fail_count(fcnt[1]), .first_fail(ffirst[1])
    );

    gates_sweep_ctrl #(.SETTLE_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .gate_a(ga[2]), .gate_b(gb[2]),
        .gate_c(gc[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .fail_mask(fmask[2]), .fail_count(fcnt[2]), .first_fail(ffirst[2])
    );

    // Observes instance k at each negedge (cycle c), then sets inputs for cycle c.
    task automatic record(input int k, input int ncyc, input int st_lo, input int st_hi,
                          input int st_x, input int rst_at, input bit glitch_en);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            obs_busy[c] = busy[k];
            obs_done[c] = done[k];
            obs_ab[c]   = {ga[k], gb[k]};
            obs_pass[c] = pass[k];
            obs_mask[c] = fmask[k];
            obs_cnt[c]  = fcnt[k];
            obs_ff[c]   = ffirst[k];
            start[k]    = ((c >= st_lo) && (c <= st_hi)) || (c == st_x);
            rst         = (c == rst_at);
            glitch      = glitch_en && (c % 2 == 1);
        end
        start  = '0;
        rst    = 1'b0;
        glitch = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = '0;
        glitch = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s0[k] = '0;
            s1[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({busy[k], done[k], ga[k], gb[k], pass[k], fmask[k], fcnt[k], ffirst[k]} !== 16'd0) begin
                fails++;
                $display("FAIL reset dut%0d outputs got %b exp all zero", k,
                         {busy[k], done[k], ga[k], gb[k], pass[k], fmask[k], fcnt[k], ffirst[k]});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_full_pass();
        logic       eb, ed;
        logic [1:0] eab;
        record(0, 15, 0, 0, -1, -1, 1'b0);
        for (int c = 1; c < 15; c++) begin
            eb  = (c <= 12);
            ed  = (c == 13);
            eab = eb ? 2'((c - 1) / 3) : 2'd0;
            tests += 3;
            if (obs_busy[c] !== eb) begin
                fails++; $display("FAIL full_pass busy c=%0d got %b exp %b", c, obs_busy[c], eb);
            end
            if (obs_done[c] !== ed) begin
                fails++; $display("FAIL full_pass done c=%0d got %b exp %b", c, obs_done[c], ed);
            end
            if (obs_ab[c] !== eab) begin
                fails++; $display("FAIL full_pass ab c=%0d got %b exp %b", c, obs_ab[c], eab);
            end
        end
        tests++;
        if ({obs_pass[13], obs_mask[13], obs_cnt[13], obs_ff[13]} !== {1'b1, 7'd0, 3'd0, 2'd0}) begin
            fails++;
            $display("FAIL full_pass result got pass=%b mask=%b cnt=%0d ff=%b exp 1/0/0/0",
                     obs_pass[13], obs_mask[13], obs_cnt[13], obs_ff[13]);
        end
    endtask

    task automatic test_c5_stuck();
        s0[0] = 7'b0010000;
        record(0, 15, 0, 0, -1, -1, 1'b0);
        s0[0] = '0;
        tests += 2;
        if (obs_pass[0] !== 1'b1) begin
            fails++; $display("FAIL c5_stuck pass held before start got %b exp 1", obs_pass[0]);
        end
        if (obs_pass[1] !== 1'b0) begin
            fails++; $display("FAIL c5_stuck pass cleared on start got %b exp 0", obs_pass[1]);
        end
        tests++;
        if ({obs_mask[7], obs_cnt[7], obs_ff[7]} !== {7'b0010000, 3'd1, 2'b01}) begin
            fails++;
            $display("FAIL c5_stuck after vec1 got mask=%b cnt=%0d ff=%b exp 0010000/1/01",
                     obs_mask[7], obs_cnt[7], obs_ff[7]);
        end
        tests++;
        if (obs_done[13] !== 1'b1) begin
            fails++; $display("FAIL c5_stuck done@13 got %b exp 1", obs_done[13]);
        end
        for (int c = 13; c < 15; c++) begin
            tests++;
            if ({obs_pass[c], obs_mask[c], obs_cnt[c], obs_ff[c]} !==
                {1'b0, 7'b0010000, 3'd2, 2'b01}) begin
                fails++;
                $display("FAIL c5_stuck result c=%0d got pass=%b mask=%b cnt=%0d ff=%b exp 0/0010000/2/01",
                         c, obs_pass[c], obs_mask[c], obs_cnt[c], obs_ff[c]);
            end
        end
    endtask

    task automatic test_stop_on_fail();
        s1[1] = 7'b0000001;
        record(1, 7, 0, 0, -1, -1, 1'b0);
        s1[1] = '0;
        for (int c = 1; c < 6; c++) begin
            tests += 2;
            if (obs_busy[c] !== (c <= 3)) begin
                fails++; $display("FAIL stop_on_fail busy c=%0d got %b exp %b", c, obs_busy[c], c <= 3);
            end
            if (obs_done[c] !== (c == 4)) begin
                fails++; $display("FAIL stop_on_fail done c=%0d got %b exp %b", c, obs_done[c], c == 4);
            end
        end
        tests++;
        if ({obs_pass[4], obs_mask[4], obs_cnt[4], obs_ff[4]} !== {1'b0, 7'b0000001, 3'd1, 2'd0}) begin
            fails++;
            $display("FAIL stop_on_fail result got pass=%b mask=%b cnt=%0d ff=%b exp 0/0000001/1/00",
                     obs_pass[4], obs_mask[4], obs_cnt[4], obs_ff[4]);
        end
    endtask

    task automatic test_mid_reset();
        int ndone;
        s1[0] = 7'b0000001;
        record(0, 30, 0, 0, -1, 6, 1'b0);
        s1[0] = '0;
        tests++;
        if (obs_cnt[5] !== 3'd1) begin
            fails++; $display("FAIL mid_reset cnt before rst got %0d exp 1", obs_cnt[5]);
        end
        tests++;
        if ({obs_busy[7], obs_done[7], obs_ab[7], obs_pass[7], obs_mask[7], obs_cnt[7], obs_ff[7]} !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset cleared got busy=%b done=%b ab=%b pass=%b mask=%b cnt=%0d ff=%b exp all 0",
                     obs_busy[7], obs_done[7], obs_ab[7], obs_pass[7], obs_mask[7], obs_cnt[7], obs_ff[7]);
        end
        ndone = 0;
        for (int c = 7; c < 30; c++) ndone += int'(obs_done[c]);
        tests++;
        if (ndone != 0) begin
            fails++; $display("FAIL mid_reset spurious done got %0d exp 0", ndone);
        end
        record(0, 15, 0, 0, -1, -1, 1'b0);
        tests++;
        if ({obs_done[13], obs_pass[13], obs_busy[12]} !== 3'b111) begin
            fails++;
            $display("FAIL mid_reset resweep got done=%b pass=%b busy12=%b exp 1/1/1",
                     obs_done[13], obs_pass[13], obs_busy[12]);
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        record(0, 16, 0, 0, 5, -1, 1'b0);
        ndone = 0;
        for (int c = 1; c < 16; c++) ndone += int'(obs_done[c]);
        tests += 2;
        if (ndone != 1) begin
            fails++; $display("FAIL busy_start done pulses got %0d exp 1", ndone);
        end
        if (obs_done[13] !== 1'b1) begin
            fails++; $display("FAIL busy_start done@13 got %b exp 1", obs_done[13]);
        end
        record(0, 30, 0, 29, -1, -1, 1'b0);
        ndone = 0;
        for (int c = 1; c < 30; c++) ndone += int'(obs_done[c]);
        tests += 3;
        if (ndone != 2) begin
            fails++; $display("FAIL held_start done pulses got %0d exp 2", ndone);
        end
        if (obs_done[13] !== 1'b1) begin
            fails++; $display("FAIL held_start done@13 got %b exp 1", obs_done[13]);
        end
        if (obs_done[27] !== 1'b1) begin
            fails++; $display("FAIL held_start done@27 got %b exp 1", obs_done[27]);
        end
    endtask

    task automatic test_settle_one();
        logic [1:0] eab;
        record(2, 12, 0, 0, -1, -1, 1'b1);
        for (int c = 1; c < 11; c++) begin
            eab = (c <= 8) ? 2'((c - 1) / 2) : 2'd0;
            tests += 3;
            if (obs_busy[c] !== (c <= 8)) begin
                fails++; $display("FAIL settle1 busy c=%0d got %b exp %b", c, obs_busy[c], c <= 8);
            end
            if (obs_done[c] !== (c == 9)) begin
                fails++; $display("FAIL settle1 done c=%0d got %b exp %b", c, obs_done[c], c == 9);
            end
            if (obs_ab[c] !== eab) begin
                fails++; $display("FAIL settle1 ab c=%0d got %b exp %b", c, obs_ab[c], eab);
            end
        end
        tests++;
        if ({obs_pass[9], obs_mask[9], obs_cnt[9]} !== {1'b1, 7'd0, 3'd0}) begin
            fails++;
            $display("FAIL settle1 glitch result got pass=%b mask=%b cnt=%0d exp 1/0/0",
                     obs_pass[9], obs_mask[9], obs_cnt[9]);
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_c5_stuck();
        test_stop_on_fail();
        test_mid_reset();
        test_back_to_back();
        test_settle_one();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
